// File: rtl/adder_req_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared adder.
interface adder_req_arbiter_if #(
    parameter int unsigned WIDTH = 6
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_sum;
    logic [1:0]       resp_valid;
    logic [WIDTH:0]   resp_sum;
    logic [1:0]       resp_ready;
    logic             busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, add_sum, resp_ready,
        output req_ready, add_a, add_b, resp_valid, resp_sum, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, add_sum, resp_ready,
        input  req_ready, add_a, add_b, resp_valid, resp_sum, busy
    );
endinterface

// File: rtl/adder_req_arbiter.sv
// Two-requester arbiter sequencing one shared combinational adder (IDLE->ISSUE->RESP).
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module adder_req_arbiter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    adder_req_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_t;

    state_t           r_state;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH:0]   r_resp_sum;
    logic [1:0]       r_resp_valid;

    logic             w_winner;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = ~bus.req_valid[0];
    end
`else
    logic r_rr_last;

    always_comb begin
        if (bus.req_valid == 2'b11) begin
            w_winner = ~r_rr_last;
        end else begin
            w_winner = ~bus.req_valid[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rr_last <= 1'b1;
        end else if (r_state == S_RESP && bus.resp_ready[r_owner]) begin
            r_rr_last <= r_owner;
        end
    end
`endif

    // Gated by reset so that every output reads zero while reset is held.
    assign w_grant = reset && (r_state == S_IDLE) && (|bus.req_valid);
    assign w_sel_a = w_winner ? bus.req_a1 : bus.req_a0;
    assign w_sel_b = w_winner ? bus.req_b1 : bus.req_b0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_resp_sum   <= '0;
            r_resp_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_owner <= w_winner;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_resp_sum   <= bus.add_sum;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_resp_valid <= '0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = w_grant ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign bus.add_a      = (r_state == S_ISSUE) ? r_op_a : '0;
    assign bus.add_b      = (r_state == S_ISSUE) ? r_op_b : '0;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_sum   = r_resp_sum;
    assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_adder_req_arbiter.sv
// Directed self-checking bench for adder_req_arbiter with a behavioural shared adder.
module tb_adder_req_arbiter;
    localparam int unsigned WIDTH = 6;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    adder_req_arbiter_if #(.WIDTH(WIDTH)) bus ();

    adder_req_arbiter #(.WIDTH(WIDTH)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] rr_order [4];
    logic [1:0] g;

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        rr_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        rr_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst_n          = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_a0     = 6'd1;
        bus.req_b0     = 6'd4;
        bus.req_a1     = 6'd4;
        bus.req_b1     = 6'd1;
        bus.resp_ready = 2'b11;
        #1;
        chk("rst_req_ready", bus.req_ready, 2'b00);
        chk("rst_resp_valid", bus.resp_valid, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_resp_sum", bus.resp_sum, 0);
        chk("rst_add_a", bus.add_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        // Round-robin with both requesters held valid from reset.
        for (int k = 0; k < 4; k++) begin
            g = rr_order[k];
            chk("rr_grant", bus.req_ready, g);
            tick();
            chk("rr_issue_a", bus.add_a, (g == 2'b01) ? 1 : 4);
            chk("rr_issue_ready", bus.req_ready, 2'b00);
            tick();
            chk("rr_resp_valid", bus.resp_valid, g);
            chk("rr_resp_sum", bus.resp_sum, 5);
            tick();
        end

        // Single request from requester 0.
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        #1;
        chk("idle_no_req", bus.req_ready, 2'b00);
        bus.req_valid = 2'b01;
        bus.req_a0    = 6'd1;
        bus.req_b0    = 6'd1;
        #1;
        chk("single_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_valid = 2'b11;
        #1;
        chk("single_add_a", bus.add_a, 1);
        chk("single_add_b", bus.add_b, 1);
        chk("single_busy", bus.busy, 1'b1);
        chk("single_no_resp", bus.resp_valid, 2'b00);
        tick();
        chk("single_resp_valid", bus.resp_valid, 2'b01);
        chk("single_resp_sum", bus.resp_sum, 2);
        chk("single_add_a_off", bus.add_a, 0);

        // Backpressure, then non-owner ready only.
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_resp_valid", bus.resp_valid, 2'b01);
            chk("bp_resp_sum", bus.resp_sum, 2);
            chk("bp_req_ready", bus.req_ready, 2'b00);
            chk("bp_busy", bus.busy, 1'b1);
        end
        bus.resp_ready = 2'b10;
        tick();
        chk("bp_nonowner", bus.resp_valid, 2'b01);
        bus.resp_ready = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("bp_exit_valid", bus.resp_valid, 2'b00);
        chk("bp_exit_busy", bus.busy, 1'b0);
        chk("bp_sum_hold", bus.resp_sum, 2);

        // Max operands from requester 1.
        bus.req_valid  = 2'b10;
        bus.req_a1     = 6'd63;
        bus.req_b1     = 6'd63;
        bus.resp_ready = 2'b00;
        #1;
        chk("max_grant", bus.req_ready, 2'b10);
        tick();
        bus.req_valid = 2'b00;
        tick();
        chk("max_resp_valid", bus.resp_valid, 2'b10);
        chk("max_resp_sum", bus.resp_sum, 126);
        bus.resp_ready = 2'b10;
        tick();

        // Operand change after accept.
        bus.resp_ready = 2'b00;
        bus.req_valid  = 2'b01;
        bus.req_a0     = 6'd10;
        bus.req_b0     = 6'd20;
        #1;
        chk("late_grant", bus.req_ready, 2'b01);
        tick();
        bus.req_a0    = 6'd3;
        bus.req_b0    = 6'd3;
        bus.req_valid = 2'b00;
        #1;
        chk("late_add_a", bus.add_a, 10);
        chk("late_add_b", bus.add_b, 20);
        tick();
        chk("late_resp_sum", bus.resp_sum, 30);
        chk("late_add_b_off", bus.add_b, 0);
        bus.resp_ready = 2'b01;
        tick();

        // Reset while in ISSUE; the last owner was requester 0.
        bus.resp_ready = 2'b11;
        bus.req_valid  = 2'b01;
        bus.req_a0     = 6'd5;
        bus.req_b0     = 6'd5;
        tick();
        chk("mid_busy_pre", bus.busy, 1'b1);
        rst_n         = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_a0    = 6'd1;
        bus.req_b0    = 6'd4;
        bus.req_a1    = 6'd4;
        bus.req_b1    = 6'd1;
        #1;
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_add_a", bus.add_a, 0);
        chk("mid_resp_valid", bus.resp_valid, 2'b00);
        chk("mid_req_ready", bus.req_ready, 2'b00);
        chk("mid_resp_sum", bus.resp_sum, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", bus.req_ready, 2'b01);
        chk("post_rst_no_resp", bus.resp_valid, 2'b00);
        tick();
        chk("post_rst_issue_resp", bus.resp_valid, 2'b00);
        tick();
        chk("post_rst_resp_valid", bus.resp_valid, 2'b01);
        chk("post_rst_resp_sum", bus.resp_sum, 5);
        bus.req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
